spi_flash_responder: RTL and testbench

SPI mode-0 target that answers the external-storage flash command set (READ 0x03, PAGE PROGRAM 0x02, WRITE ENABLE 0x06, READ STATUS 0x05) from a byte-wide backing-memory port. It is the far end of the storage controller's SPI master link. It is used as a synthesizable flash stand-in on the FPGA bring-up board and as the SPI responder in system benches. All SPI inputs are asynchronous to `clk` and are oversampled.

---
 rtl/spi_flash_responder.sv | 214 +++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder (READ 0x03, PP 0x02, WREN 0x06, RDSR 0x05) over a byte-wide memory port.
// Define SPI_FLASH_RESPONDER_FAST_READ_EN to also decode FAST READ 0x0B with 8 dummy clocks.
module spi_flash_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs_n,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              wel,
  output logic              underrun
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, RDATA, WDATA, STATUS, IGNORE
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
    , DUMMY
`endif
  } state_t;

  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
  logic cs_prev, sck_prev, cs_s, sck_s, mosi_s;
  logic cs_fall, cs_rise, sck_rise, sck_fall;

  state_t            state_q, state_d;
  logic [5:0]        bit_cnt;
  logic [6:0]        sh_in;
  logic [7:0]        byte_in, sh_out, rd_buf;
  logic [ADDR_W-1:0] addr, addr_in;
  logic              is_prog, rd_valid, prog_got;
  logic              byte_done, addr_done, fetching, rd_ack;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
  logic              is_fast;
`endif

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign cs_fall  = cs_prev & ~cs_s;
  assign cs_rise  = ~cs_prev & cs_s;
  assign sck_rise = ~sck_prev & sck_s;
  assign sck_fall = sck_prev & ~sck_s;

  // Synchronizers reset to the idle bus: deselected, clock low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_sync   <= '1;
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_prev   <= 1'b1;
      sck_prev  <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_prev   <= cs_s;
      sck_prev  <= sck_s;
    end
  end

  assign byte_in   = {sh_in, mosi_s};
  assign addr_in   = {addr[ADDR_W-2:0], mosi_s};
  assign byte_done = sck_rise && (bit_cnt[2:0] == 3'd7);
  assign addr_done = sck_rise && (bit_cnt == 6'(ADDR_W-1));
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
  assign fetching  = (state_q == RDATA) || (state_q == DUMMY);
`else
  assign fetching  = (state_q == RDATA);
`endif
  assign rd_ack    = mem_ack && !mem_we && fetching;
  assign spi_miso  = spi_miso_oe & sh_out[7];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cs_rise) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: if (cs_fall) state_d = CMD;
        CMD: if (byte_done) begin
          case (byte_in)
            8'h03:   state_d = ADDR;
            8'h02:   state_d = wel ? ADDR : IGNORE;
            8'h05:   state_d = STATUS;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
            8'h0B:   state_d = ADDR;
`endif
            default: state_d = IGNORE;
          endcase
        end
        ADDR: if (addr_done) begin
          if (is_prog) state_d = WDATA;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
          else if (is_fast) state_d = DUMMY;
`endif
          else state_d = RDATA;
        end
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
        DUMMY: if (byte_done) state_d = RDATA;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt     <= '0;
      sh_in       <= '0;
      sh_out      <= '0;
      rd_buf      <= '0;
      addr        <= '0;
      is_prog     <= 1'b0;
      rd_valid    <= 1'b0;
      prog_got    <= 1'b0;
      spi_miso_oe <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      wel         <= 1'b0;
      underrun    <= 1'b0;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
      is_fast     <= 1'b0;
`endif
    end else begin
      // Output-side states count falling edges, everything else counts rising edges.
      if (state_d != state_q || cs_fall) bit_cnt <= '0;
      else if (state_q == ADDR) begin
        if (sck_rise) bit_cnt <= bit_cnt + 6'd1;
      end else if (state_q == RDATA || state_q == STATUS) begin
        if (sck_fall) bit_cnt <= {3'b0, bit_cnt[2:0] + 3'd1};
      end else if (sck_rise) bit_cnt <= {3'b0, bit_cnt[2:0] + 3'd1};

      if (mem_ack) mem_req <= 1'b0;
      if (rd_ack) begin
        rd_buf   <= mem_rdata;
        rd_valid <= 1'b1;
      end
      if (sck_rise) sh_in <= byte_in[6:0];

      if (cs_rise) begin
        spi_miso_oe <= 1'b0;
        sh_out      <= '0;
        rd_valid    <= 1'b0;
        if (state_q == WDATA && prog_got) wel <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (cs_fall) begin
            underrun <= 1'b0;
            prog_got <= 1'b0;
          end
          CMD: if (byte_done) begin
            if (byte_in == 8'h06) wel <= 1'b1;
            is_prog <= (byte_in == 8'h02);
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
            is_fast <= (byte_in == 8'h0B);
`endif
          end
          ADDR: if (sck_rise) begin
            addr <= addr_in;
            if (addr_done && !is_prog) begin
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= addr_in;
            end
          end
          RDATA, STATUS: if (sck_fall) begin
            if (bit_cnt[2:0] == 3'd0) begin
              spi_miso_oe <= 1'b1;
              if (state_q == STATUS) sh_out <= {6'b0, wel, 1'b0};
              else if (rd_valid || rd_ack) begin
                // Ack on the load edge bypasses the buffer so no byte is lost.
                sh_out   <= rd_ack ? mem_rdata : rd_buf;
                rd_valid <= 1'b0;
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= addr + ADDR_W'(1);
                addr     <= addr + ADDR_W'(1);
              end else begin
                sh_out   <= 8'hFF;
                underrun <= 1'b1;
              end
            end else sh_out <= {sh_out[6:0], 1'b0};
          end
          WDATA: if (byte_done) begin
            prog_got <= 1'b1;
            if (mem_req && !mem_ack) underrun <= 1'b1;
            else begin
              mem_req    <= 1'b1;
              mem_we     <= 1'b1;
              mem_addr   <= addr;
              mem_wdata  <= byte_in;
              addr[7:0]  <= addr[7:0] + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: bit-banged SPI master plus a latency-programmable memory model.
module tb_spi_flash_responder;
  logic        clk, rst, spi_cs_n, spi_sck, spi_mosi;
  logic        spi_miso, spi_miso_oe, mem_req, mem_we, mem_ack, wel, underrun;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  spi_flash_responder #(.SYNC_STAGES(2), .ADDR_W(24)) dut (
    .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wel(wel), .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk, n_pass;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Memory model: ack arrives ack_lat cycles after the request is seen.
  logic [7:0]  mem [0:4095];
  int          ack_lat, busy_cnt, n_req;
  logic        busy, req_we;
  logic [23:0] req_addr;
  logic [7:0]  req_wd;
  logic [23:0] rd_log[$];
  logic [31:0] wr_log[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_ack  <= 1'b0;
      busy     <= 1'b0;
      busy_cnt <= 0;
      n_req    <= 0;
      mem_rdata <= 8'h00;
      req_we   <= 1'b0;
      req_addr <= '0;
      req_wd   <= '0;
      mem[12'h000] <= 8'hA5;
      mem[12'h001] <= 8'h5A;
      mem[12'h002] <= 8'h3C;
      mem[12'hFFF] <= 8'h77;
    end else begin
      mem_ack <= 1'b0;
      if (busy) begin
        busy_cnt <= busy_cnt + 1;
        if (busy_cnt + 1 >= ack_lat) begin
          mem_ack <= 1'b1;
          busy    <= 1'b0;
          if (req_we) begin
            mem[req_addr[11:0]] <= req_wd;
            wr_log.push_back({req_addr, req_wd});
          end else begin
            mem_rdata <= mem[req_addr[11:0]];
            rd_log.push_back(req_addr);
          end
        end
      end else if (mem_req && !mem_ack) begin
        busy     <= 1'b1;
        busy_cnt <= 1;
        req_addr <= mem_addr;
        req_we   <= mem_we;
        req_wd   <= mem_wdata;
        n_req    <= n_req + 1;
      end
    end
  end

  // sck period is 16 clk; miso sampled on the rising edge like a mode-0 master.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi_mosi = tx[7-i];
      repeat (8) @(negedge clk);
      spi_sck = 1'b1;
      rx = {rx[6:0], spi_miso};
      repeat (8) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic xb(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic cs_lo();
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_hi();
    repeat (8) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (24) @(negedge clk);
  endtask

  logic [7:0] r0, r1, r2, dmy;
  int n0;

  initial begin
    n_chk = 0; n_pass = 0; ack_lat = 2;
    rst = 1'b0; spi_cs_n = 1'b0; spi_sck = 1'b0; spi_mosi = 1'b0;
    for (int i = 0; i < 10; i++) begin
      repeat (2) @(negedge clk);
      spi_sck = ~spi_sck;
    end
    chk("rst_miso", {spi_miso, spi_miso_oe}, 0);
    chk("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
    chk("rst_flags", {wel, underrun}, 0);
    spi_cs_n = 1'b1; spi_sck = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // READ 0x001000, three bytes
    rd_log.delete();
    cs_lo(); xb(8'h03, dmy); xb(8'h00, dmy); xb(8'h10, dmy); xb(8'h00, dmy);
    xb(8'h00, r0); xb(8'h00, r1); xb(8'h00, r2);
    repeat (4) @(negedge clk);
    chk("rd_oe", spi_miso_oe, 1);
    cs_hi();
    chk("rd_b0", r0, 8'hA5);
    chk("rd_b1", r1, 8'h5A);
    chk("rd_b2", r2, 8'h3C);
    for (int i = 0; i < 3; i++)
      chk("rd_addr", (i < rd_log.size()) ? rd_log[i] : 24'hDEAD00, 24'h001000 + 24'(i));
    chk("rd_unr", underrun, 0);
    chk("rd_idle_oe", {spi_miso, spi_miso_oe}, 0);

    // WREN then PAGE PROGRAM across the page end
    cs_lo(); xb(8'h06, dmy); cs_hi();
    chk("wren_wel", wel, 1);
    wr_log.delete();
    cs_lo(); xb(8'h02, dmy); xb(8'h00, dmy); xb(8'h02, dmy); xb(8'hFE, dmy);
    xb(8'h11, dmy); xb(8'h22, dmy); xb(8'h33, dmy); cs_hi();
    chk("pp_nwr", wr_log.size(), 3);
    chk("pp_w0", (wr_log.size() > 0) ? wr_log[0] : 32'hDEAD, 32'h0002FE11);
    chk("pp_w1", (wr_log.size() > 1) ? wr_log[1] : 32'hDEAD, 32'h0002FF22);
    chk("pp_w2", (wr_log.size() > 2) ? wr_log[2] : 32'hDEAD, 32'h00020033);
    chk("pp_wel", wel, 0);

    // PROGRAM without WEL is ignored; status reflects WEL
    n0 = n_req;
    cs_lo(); xb(8'h02, dmy); xb(8'h00, dmy); xb(8'h00, dmy); xb(8'h00, dmy); xb(8'hAB, dmy); cs_hi();
    chk("pp_nowel_req", n_req - n0, 0);
    cs_lo(); xb(8'h05, dmy); xb(8'h00, r0); cs_hi();
    chk("rdsr_0", r0, 8'h00);
    cs_lo(); xb(8'h06, dmy); cs_hi();
    cs_lo(); xb(8'h05, dmy); xb(8'h00, r0); xb(8'h00, r1); cs_hi();
    chk("rdsr_1", r0, 8'h02);
    chk("rdsr_rep", r1, 8'h02);

    // Partial data byte: no write, WEL kept
    n0 = n_req;
    cs_lo(); xb(8'h02, dmy); xb(8'h00, dmy); xb(8'h03, dmy); xb(8'h00, dmy);
    spi_bits(8'hC0, 5, dmy); cs_hi();
    chk("part_req", n_req - n0, 0);
    chk("part_wel", wel, 1);

    // Slow memory: first byte underruns, address held for the next byte
    ack_lat = 10;
    rd_log.delete();
    cs_lo(); xb(8'h03, dmy); xb(8'h00, dmy); xb(8'h10, dmy); xb(8'h00, dmy);
    xb(8'h00, r0); xb(8'h00, r1); cs_hi();
    chk("unr_b0", r0, 8'hFF);
    chk("unr_b1", r1, 8'hA5);
    chk("unr_flag", underrun, 1);
    cs_lo();
    chk("unr_clr", underrun, 0);
    cs_hi();
    ack_lat = 2;

`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
    cs_lo(); xb(8'h0B, dmy); xb(8'hFF, dmy); xb(8'hFF, dmy); xb(8'hFF, dmy);
    xb(8'h00, dmy); xb(8'h00, r0); xb(8'h00, r1); cs_hi();
    chk("fast_b0", r0, 8'h77);
    chk("fast_b1", r1, 8'hA5);
`else
    n0 = n_req;
    cs_lo(); xb(8'h0B, dmy); xb(8'hFF, dmy); xb(8'hFF, dmy); xb(8'hFF, dmy);
    xb(8'h00, r0); cs_hi();
    chk("fast_off_req", n_req - n0, 0);
    chk("fast_off_miso", r0, 8'h00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
